// File: rtl/memory_copy_engine.sv
// memory_copy_engine
//   Copies word_count 32-bit words from source_address to destination_address,
//   one word at a time: a READ cycle captures the source word, the following
//   WRITE cycle stores it. Addresses are forced to word alignment.
//
// Ports
//   clock                 single clock, rising edge
//   reset                 synchronous active-high reset
//   start                 copy request, sampled only in IDLE
//   source_address        byte address of first source word
//   destination_address   byte address of first destination word
//   word_count            number of words to copy (0 = no memory access)
//   busy                  high in READ and WRITE
//   done                  one-cycle completion pulse
//   memory_address        word-aligned address to the data memory
//   memory_write_enable   write strobe (gated low while reset is high)
//   memory_write_data     write word
//   memory_read_data      combinational read data for memory_address
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// READ  | source word presented, captured into holding register at the edge
// WRITE | holding register written to destination; pointers advance
// DONE  | one-cycle done pulse, back to IDLE
module memory_copy_engine #(
  parameter int count_width = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            source_address,
  input  logic [31:0]            destination_address,
  input  logic [count_width-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            memory_address,
  output logic                   memory_write_enable,
  output logic [31:0]            memory_write_data,
  input  logic [31:0]            memory_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [count_width-1:0] count_one = count_width'(1);

  state_t                 state;
  state_t                 next_state;
  logic [31:0]            source_pointer;
  logic [31:0]            destination_pointer;
  logic [count_width-1:0] remaining;
  logic [31:0]            holding;

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      source_pointer      <= '0;
      destination_pointer <= '0;
      remaining           <= '0;
      holding             <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (start) begin
            source_pointer      <= source_address;
            destination_pointer <= destination_address;
            remaining           <= word_count;
          end
        end
        READ: begin
          holding <= memory_read_data;
        end
        WRITE: begin
          // 32-bit adders wrap naturally modulo 2**32
          source_pointer      <= source_pointer + 32'd4;
          destination_pointer <= destination_pointer + 32'd4;
          remaining           <= remaining - count_one;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state          = state;
    busy                = 1'b0;
    done                = 1'b0;
    memory_address      = '0;
    memory_write_enable = 1'b0;
    memory_write_data   = '0;
    unique case (state)
      IDLE: begin
        if (start) next_state = (word_count != '0) ? READ : DONE;
      end
      READ: begin
        busy           = 1'b1;
        memory_address = {source_pointer[31:2], 2'b00};
        next_state     = WRITE;
      end
      WRITE: begin
        busy                = 1'b1;
        memory_address      = {destination_pointer[31:2], 2'b00};
        // a write must never commit at a reset edge
        memory_write_enable = ~reset;
        memory_write_data   = holding;
        next_state          = (remaining == count_one) ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_copy_engine.sv
// Testbench for memory_copy_engine: behavioural memory, reference copy model,
// scoreboard of expected writes/done pulses checked by a separate monitor.
module tb_memory_copy_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] source_address = '0;
  logic [31:0] destination_address = '0;
  logic [6:0]  word_count = '0;
  logic        busy;
  logic        done;
  logic [31:0] memory_address;
  logic        memory_write_enable;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  tests = 0;
  int  failed = 0;

  memory_copy_engine #(.count_width(7)) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .source_address      (source_address),
    .destination_address (destination_address),
    .word_count          (word_count),
    .busy                (busy),
    .done                (done),
    .memory_address      (memory_address),
    .memory_write_enable (memory_write_enable),
    .memory_write_data   (memory_write_data),
    .memory_read_data    (memory_read_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign memory_read_data = mem[memory_address[11:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or pulses done.
  always @(negedge clock) begin
    #2;
    if (memory_write_enable) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("write_addr", memory_address, e.addr);
        chk("write_data", memory_write_data, e.data);
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
    end
  end

  task automatic mem_compare();
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image_mismatches", 32'(bad), 32'd0);
  endtask

  // One copy. glitch: extra start with other addresses in cycle N+3.
  // abort_at: offset from N of the cycle in which reset is raised (0 = none).
  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int k,
                         input bit glitch, input int abort_at);
    logic [31:0] s_al, d_al, ra, wa, d, exp_addr;
    logic        active, exp_we;
    int          n, last;
    @(negedge clock);
    reset = 1'b0;
    source_address = src;
    destination_address = dst;
    word_count = 7'(k);
    start = 1'b1;
    n = cyc;
    #1;
    chk("idle_busy_before_start", {31'd0, busy}, 32'd0);
    chk("idle_addr_before_start", memory_address, 32'd0);
    s_al = {src[31:2], 2'b00};
    d_al = {dst[31:2], 2'b00};
    for (int i = 0; i < k; i++) begin
      if (abort_at != 0 && 2 + 2 * i >= abort_at) break;
      ra = s_al + 32'(4 * i);
      wa = d_al + 32'(4 * i);
      d  = ref_mem[ra[11:2]];
      ref_mem[wa[11:2]] = d;
      wq.push_back('{wa, d, n + 2 + 2 * i});
    end
    if (abort_at == 0) dq.push_back(k == 0 ? n + 1 : n + 2 * k + 1);
    last = (abort_at != 0) ? abort_at : ((k == 0) ? 2 : 2 * k + 2);
    for (int t = 1; t <= last; t++) begin
      @(negedge clock);
      if (t == 1) begin
        start = 1'b0;
        source_address = $urandom;
        destination_address = $urandom;
        word_count = 7'($urandom);
      end
      if (glitch && t == 3) begin
        start = 1'b1;
        source_address = $urandom;
        destination_address = $urandom;
        word_count = 7'($urandom_range(1, 127));
      end
      if (glitch && t == 4) start = 1'b0;
      if (abort_at != 0 && t == abort_at) reset = 1'b1;
      #1;
      active = (k > 0) && (t <= 2 * k);
      if (active) begin
        if (t % 2 == 1) exp_addr = s_al + 32'(2 * (t - 1));
        else exp_addr = d_al + 32'(2 * t - 4);
        exp_we = (t % 2 == 0) && (t != abort_at);
      end else begin
        exp_addr = '0;
        exp_we = 1'b0;
        chk("quiet_wdata", memory_write_data, 32'd0);
      end
      chk("busy", {31'd0, busy}, {31'd0, active});
      chk("mem_addr", memory_address, exp_addr);
      chk("write_enable", {31'd0, memory_write_enable}, {31'd0, exp_we});
    end
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    mem_compare();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    fork
      forever begin
        @(posedge clock);
        if (memory_write_enable) mem[memory_address[11:2]] = memory_write_data;
      end
    join_none

    repeat (3) @(negedge clock);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_we", {31'd0, memory_write_enable}, 32'd0);
    chk("reset_addr", memory_address, 32'd0);

    // reset wins over start
    @(negedge clock);
    reset = 1'b1; start = 1'b1; word_count = 7'd5;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    #1;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    chk("rst_prio_done", {31'd0, done}, 32'd0);

    // directed three-word copy
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;
    do_copy(32'h0, 32'h80, 3, 1'b0, 0);
    chk("dst_word0", mem[32], 32'h11);
    chk("dst_word2", mem[34], 32'h33);

    // zero count
    do_copy(32'h100, 32'h200, 0, 1'b0, 0);

    // start during a copy is ignored
    do_copy(32'h10, 32'h300, 3, 1'b1, 0);

    // reset in WRITE of word 2, then immediate restart
    do_copy(32'h20, 32'h400, 3, 1'b0, 4);
    do_copy(32'h40, 32'h500, 1, 1'b0, 0);

    // misaligned addresses
    do_copy(32'h03, 32'h41, 1, 1'b0, 0);

    // pointer wrap
    do_copy(32'hFFFF_FFFC, 32'h600, 2, 1'b0, 0);
    do_copy(32'h700, 32'hFFFF_FFF8, 3, 1'b0, 0);

    // maximum length
    do_copy(32'h800, 32'hA00, 127, 1'b0, 0);

    // randomized, frequently overlapping regions
    for (int r = 0; r < 30; r++) begin
      do_copy(32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3)),
              32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3)),
              $urandom_range(0, 12), 1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/memory_copy_engine.md
MEMORY_COPY_ENGINE -- requirements
Module: memory_copy_engine

Interface
REQ-001 Parameter count_width, default 7, SHALL set the width of word_count (maximum copy length 2**count_width-1 words).
REQ-002 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start  input  1  SHALL be the copy request, sampled only in IDLE.
REQ-005 source_address  input  32  SHALL be the byte address of the first word to read.
REQ-006 destination_address  input  32  SHALL be the byte address of the first word to write.
REQ-007 word_count  input  count_width  SHALL be the number of 32-bit words to copy.
REQ-008 busy  output  1  SHALL be high while a copy is in progress.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 memory_address  output  32  SHALL be the address presented to a word-aligned, combinational-read, rising-edge-write data memory.
REQ-011 memory_write_enable  output  1  SHALL be the memory write strobe.
REQ-012 memory_write_data  output  32  SHALL be the memory write word.
REQ-013 memory_read_data  input  32  SHALL be the memory's combinational read data for memory_address.

Function
REQ-014 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-015 In IDLE with start=1 at an edge, the engine SHALL snapshot source_address, destination_address and word_count, then go to READ if word_count>0, else to DONE.
REQ-016 In IDLE, later changes to the snapshot inputs SHALL NOT affect a copy in progress.
REQ-017 READ: memory_address = current source pointer with bits [1:0] forced to 00; memory_write_enable=0; memory_read_data captured into a holding register at the edge; next state WRITE.
REQ-018 WRITE: memory_address = current destination pointer with bits [1:0] forced to 00; memory_write_enable=1; memory_write_data = holding register.
REQ-019 At the edge ending WRITE, both pointers SHALL advance by 4 and the remaining count SHALL decrement by 1. The next state SHALL be READ if the remaining count is still nonzero, else DONE.
REQ-020 Pointer increment SHALL wrap modulo 2**32 (0xFFFFFFFC+4 = 0x00000000).
REQ-021 Copy order SHALL be strictly ascending. Overlapping regions get no special handling, and each word is read immediately before its write.
REQ-022 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 start SHALL be ignored in READ, WRITE and DONE.
REQ-024 busy SHALL be 1 exactly in READ and WRITE.
REQ-025 Latency: with start accepted at edge N and count k>0, busy SHALL be high for cycles N+1..N+2k, and done SHALL be high in cycle N+2k+1. With k=0, done SHALL be high in cycle N+1 and no memory access occurs.
REQ-026 In IDLE and DONE, memory_address and memory_write_data SHALL be 0 and memory_write_enable SHALL be 0.

Reset
REQ-027 At a rising edge with reset=1, the FSM SHALL enter IDLE, clear the pointers, count and holding register, and set busy=0 and done=0.
REQ-028 memory_write_enable SHALL be combinationally gated low in any cycle where reset=1, including a WRITE cycle, so that no write commits at the reset edge.
REQ-029 Reset mid-copy SHALL abandon the copy: words already written remain, no done pulse is emitted, and a new start is accepted in the first cycle after reset deasserts.
REQ-030 Reset SHALL take priority over start in the same cycle.

Verification
REQ-031 Memory preloaded with 0x11, 0x22, 0x33 at 0x00, 0x04, 0x08; start with src=0x00, dst=0x80, count=3 at edge N -> writes of 0x11@0x80, 0x22@0x84, 0x33@0x88 in cycles N+2, N+4, N+6; busy high N+1..N+6; done high in N+7 only.
REQ-032 count=0 -> memory_write_enable never asserted; busy stays 0; done high in cycle N+1.
REQ-033 Second start with different addresses pulsed during cycle N+3 of a count=3 copy -> ignored; the original copy completes unchanged.
REQ-034 reset asserted in the WRITE cycle of word 2 of a count=3 copy -> memory_write_enable low in that cycle; only word 1 written; busy=0 and done never pulses; a following start with count=1 completes normally.
REQ-035 src=0x03, dst=0x41, count=1 -> memory_address 0x00 in READ and 0x40 in WRITE.
REQ-036 src=0xFFFFFFFC, count=2 -> READ addresses 0xFFFFFFFC then 0x00000000.
